// File: rtl/pipe_compress_tree.sv
// Pipelined 3:2 carry-save compressor tree for Booth partial products, valid/ready handshake.
// Optional carry-propagate output stage enabled by defining PIPE_COMPRESS_TREE_FINAL_ADD_EN.
module pipe_compress_tree #(
    parameter int W         = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [(W/2+1)*(W+2)-1:0]   pp,
    input  logic [W/2-1:0]             neg,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*W-1:0]             out_s,
    output logic [2*W-1:0]             out_c,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int NPP = W / 2 + 1;
    localparam int R0  = NPP + 1;
    localparam int W2  = 2 * W;

    function automatic int next_rows(input int r);
        return 2 * (r / 3) + (r % 3);
    endfunction

    function automatic int rows_at(input int lvl);
        int r;
        r = R0;
        for (int i = 0; i < lvl; i++) r = next_rows(r);
        return r;
    endfunction

    function automatic int calc_depth();
        int r;
        int d;
        r = R0;
        d = 0;
        while (r > 2) begin
            r = next_rows(r);
            d++;
        end
        return d;
    endfunction

    localparam int D = calc_depth();
    localparam int L = (D + REG_EVERY - 1) / REG_EVERY;
`ifdef PIPE_COMPRESS_TREE_FINAL_ADD_EN
    localparam int NST = L + 1;
`else
    localparam int NST = L;
`endif

    // Weighted, sign-extended rows feeding the first reduction level
    logic [W2-1:0] init_rows [R0];
    logic [W2-1:0] neg_row;
    logic          unused_pp_hi;

    assign unused_pp_hi = ^pp[(NPP-1)*(W+2)+W +: 2];

    always_comb begin
        neg_row = '0;
        for (int i = 0; i < W / 2; i++) neg_row[2*i] = neg[i];
        for (int i = 0; i < W / 2; i++) begin
            init_rows[i] = {{(W-2){pp[i*(W+2)+W+1]}}, pp[i*(W+2) +: W+2]} << (2 * i);
        end
        init_rows[NPP-1] = {pp[(NPP-1)*(W+2) +: W], {W{1'b0}}};
        init_rows[R0-1]  = neg_row;
    end

    // Per-stage handshake state
    logic [NST-1:0]   valid_d, valid_q;
    logic [NST-1:0]   stage_ready, stage_load, stage_in_valid;
    logic [TAG_W-1:0] tag_d [NST];
    logic [TAG_W-1:0] tag_q [NST];
    logic [TAG_W-1:0] stage_in_tag [NST];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NST; gi++) begin : gen_stg
            if (gi == 0) begin : gen_first
                assign stage_in_valid[gi] = in_valid;
                assign stage_in_tag[gi]   = in_tag;
            end else begin : gen_next
                assign stage_in_valid[gi] = valid_q[gi-1];
                assign stage_in_tag[gi]   = tag_q[gi-1];
            end
        end
    endgenerate

    // A stage can take data if it, or any stage after it, has a hole, or the sink drains
    always_comb begin
        stage_ready = '0;
        for (int k = 0; k < NST; k++) begin
            stage_ready[k] = out_ready;
            for (int j = k; j < NST; j++) begin
                if (!valid_q[j]) stage_ready[k] = 1'b1;
            end
        end
        stage_load = stage_ready & stage_in_valid;
        for (int k = 0; k < NST; k++) begin
            valid_d[k] = stage_ready[k] ? stage_in_valid[k] : valid_q[k];
            tag_d[k]   = stage_load[k] ? stage_in_tag[k] : tag_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < NST; k++) tag_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign in_ready  = stage_ready[0] & ~rst;
    assign out_valid = valid_q[NST-1];
    assign out_tag   = tag_q[NST-1];

    generate
        for (gi = 0; gi < D; gi++) begin : gen_lvl
            localparam int  RI     = rows_at(gi);
            localparam int  RO     = rows_at(gi + 1);
            localparam int  NG     = RI / 3;
            localparam bit  IS_REG = ((gi + 1) % REG_EVERY == 0) || (gi == D - 1);

            logic [W2-1:0] in_rows  [RI];
            logic [W2-1:0] out_rows [RO];
            logic [W2-1:0] nxt_rows [RO];

            if (gi == 0) begin : gen_src
                assign in_rows = init_rows;
            end else begin : gen_src
                assign in_rows = gen_lvl[gi-1].nxt_rows;
            end

            for (gj = 0; gj < NG; gj++) begin : gen_csa
                assign out_rows[2*gj]   = in_rows[3*gj] ^ in_rows[3*gj+1] ^ in_rows[3*gj+2];
                assign out_rows[2*gj+1] = ((in_rows[3*gj] & in_rows[3*gj+1]) |
                                           (in_rows[3*gj] & in_rows[3*gj+2]) |
                                           (in_rows[3*gj+1] & in_rows[3*gj+2])) << 1;
            end

            for (gj = 0; gj < RI % 3; gj++) begin : gen_pass
                assign out_rows[2*NG+gj] = in_rows[3*NG+gj];
            end

            if (IS_REG) begin : gen_reg
                localparam int STG = gi / REG_EVERY;
                logic [W2-1:0] rows_d [RO];
                logic [W2-1:0] rows_q [RO];

                always_comb begin
                    rows_d = rows_q;
                    if (stage_load[STG]) rows_d = out_rows;
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int j = 0; j < RO; j++) rows_q[j] <= '0;
                    end else begin
                        rows_q <= rows_d;
                    end
                end

                assign nxt_rows = rows_q;
            end else begin : gen_comb
                assign nxt_rows = out_rows;
            end
        end
    endgenerate

`ifdef PIPE_COMPRESS_TREE_FINAL_ADD_EN
    logic [W2-1:0] sum_d, sum_q;

    always_comb begin
        sum_d = sum_q;
        if (stage_load[L]) sum_d = gen_lvl[D-1].nxt_rows[0] + gen_lvl[D-1].nxt_rows[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign out_s = sum_q;
    assign out_c = '0;
`else
    assign out_s = gen_lvl[D-1].nxt_rows[0];
    assign out_c = gen_lvl[D-1].nxt_rows[1];
`endif

endmodule

// File: doc/pipe_compress_tree.md
PIPE_COMPRESS_TREE -- requirements
Module: pipe_compress_tree

Interface
REQ-001 SHALL have parameter W, default 32, meaning multiplier operand width (even, 8..64).
REQ-002 SHALL have parameter REG_EVERY, default 2, meaning the number of 3:2 reduction levels between pipeline registers (1..4).
REQ-003 SHALL have parameter TAG_W, default 4, meaning the width of the sideband tag carried alongside each operation.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an input beat this cycle.
REQ-008 SHALL have port pp, input, NPP*(W+2) bits: Booth partial products, where NPP=W/2+1 and row i occupies bits [i*(W+2) +: W+2].
REQ-009 SHALL have port neg, input, W/2 bits: Booth negate-correction bits; neg[i] has weight 2^(2i).
REQ-010 SHALL have port in_tag, input, TAG_W bits: sideband tag.
REQ-011 SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.
REQ-013 SHALL have port out_s, output, 2W bits: carry-save sum vector.
REQ-014 SHALL have port out_c, output, 2W bits: carry-save carry vector.
REQ-015 SHALL have port out_tag, output, TAG_W bits: the tag of the beat on the output.

Function
REQ-016 Rows 0..W/2-1 of pp SHALL be treated as two's-complement and sign-extended; row W/2 SHALL be treated as unsigned, using its low W bits only.
REQ-017 The block SHALL satisfy out_s + out_c == sum over i of (pp_i << 2i) + sum over i of (neg[i] << 2i), modulo 2^(2W).
REQ-018 Reduction SHALL use 3:2 carry-save levels starting from R0=NPP+1 rows (the neg bits form one row); each level maps R rows to 2*floor(R/3) + (R mod 3) rows, until 2 rows remain.
REQ-019 The level count D SHALL be derived from R0 at elaboration; for W=32, R0=18 and D=6.
REQ-020 A pipeline register SHALL follow every REG_EVERY-th level and the final level, giving a latency L=ceil(D/REG_EVERY) cycles (L=3 at the defaults).
REQ-021 Each stage SHALL carry a valid bit and the tag; the tag SHALL exit aligned with its own data.
REQ-022 A stage SHALL load when its downstream stage is empty or advancing in the same cycle; bubbles SHALL collapse.
REQ-023 Under backpressure (out_ready=0), up to L beats SHALL be held; in_ready SHALL equal (first stage empty) OR (first stage advancing).
REQ-024 in_ready SHALL NOT depend combinationally on in_valid.
REQ-025 A transfer SHALL occur on in_valid&in_ready on the input side and on out_valid&out_ready on the output side.
REQ-026 Beats SHALL leave in arrival order, with none lost or duplicated.
REQ-027 out_s, out_c and out_tag SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 A simultaneous input accept and output drain on a full pipeline SHALL sustain a throughput of 1 beat per cycle.

Reset
REQ-029 While rst is high, all stage valid bits SHALL clear asynchronously; out_valid=0, out_s=0, out_c=0 and out_tag=0.
REQ-030 in_ready SHALL be 0 while rst is high, and SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats; no partial beat SHALL appear afterwards.

Configuration
REQ-032 When macro PIPE_COMPRESS_TREE_FINAL_ADD_EN is defined, the block SHALL add one registered carry-propagate stage: out_s=(S+C) mod 2^(2W), out_c=0, and latency L+1 with identical handshake rules.
REQ-033 When the macro is undefined, the outputs SHALL be the raw carry-save pair with latency L.

Verification
REQ-034 W=32 defaults: pp row0=5, all other rows and neg=0, in_tag=3, out_ready=1 -> out_valid after 3 cycles, out_s+out_c=5, out_tag=3.
REQ-035 pp row1=all ones (-1), neg[1]=1, other rows 0 -> out_s+out_c=0 mod 2^64.
REQ-036 Booth encoding of 0xFFFFFFFF*0xFFFFFFFF fed as pp/neg -> out_s+out_c=0xFFFFFFFE00000001.
REQ-037 out_ready=0 with 5 consecutive beats offered (tags 1..5) -> in_ready=0 after 3 beats accepted; release out_ready -> tags 1,2,3,4,5 emerge in order on consecutive cycles.
REQ-038 rst pulsed high with 2 beats in flight -> out_valid=0 immediately, no stale beat appears after release, in_ready=1 on the next cycle.
REQ-039 With PIPE_COMPRESS_TREE_FINAL_ADD_EN defined, repeat REQ-036 -> out_s=0xFFFFFFFE00000001, out_c=0, latency 4.
